// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and packed-slice helper for the multi-port register file
package regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode-stage bus of the register file
// Signals: ready, rd_num/rd_data/rd_busy (read ports), wr_en/wr_num/wr_data (writeback ports),
//          sb_set_en/sb_set_num (issue marks a register pending).
// Modports: master drives indices/writes/issue, slave is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic                     ready;
    logic [NUM_RD*ADDR_W-1:0] rd_num;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_num;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_num;
    modport master (
        input  ready, rd_data, rd_busy,
        output rd_num, wr_en, wr_num, wr_data, sb_set_en, sb_set_num
    );
    modport slave (
        output ready, rd_data, rd_busy,
        input  rd_num, wr_en, wr_num, wr_data, sb_set_en, sb_set_num
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register; issue sets, writeback clears, set beats clear
// Ports: clk, rst_n (async active-low); wr_en/wr_num clear bits; sb_set_en/sb_set_num set a bit;
//        rd_num in, rd_busy out (registered bit of each read index).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_num,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_num,
    input  logic [NUM_RD*ADDR_W-1:0] rd_num,
    output logic [NUM_RD-1:0]        rd_busy
);
    logic [NUM_REGS-1:0] sb, sb_nxt;

    // Set applied after clears so a new issue supersedes an old writeback; bit 0 never pends.
    always_comb begin
        sb_nxt = sb;
        for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j]) sb_nxt[wr_num[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b0;
        if (sb_set_en) sb_nxt[sb_set_num] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sb <= '0;
        else sb <= sb_nxt;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        assign rd_busy[i] = sb[rd_num[slice_lo(i, ADDR_W) +: ADDR_W]];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with post-reset clear sequencer and pending-write scoreboard
// Ports: clk; rst_n (async active-low); bus (regfile_mp_if.slave): ready, rd_num/rd_data/rd_busy,
//        wr_en/wr_num/wr_data, sb_set_en/sb_set_num.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                run;
    logic [NUM_WR-1:0]   wr_act;
    logic [NUM_RD-1:0]   sb_busy;
    logic [ADDR_W-1:0]   wn [NUM_WR];
    logic [DATA_W-1:0]   wd [NUM_WR];

    assign run       = state == RUN;
    assign bus.ready = run;
    assign wr_act    = bus.wr_en & {NUM_WR{run}};

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wn[w] = bus.wr_num[slice_lo(w, ADDR_W) +: ADDR_W];
        assign wd[w] = bus.wr_data[slice_lo(w, DATA_W) +: DATA_W];
    end

    always_comb state_nxt = (state == CLEAR && clr_ptr == ADDR_W'(NUM_REGS - 1)) ? RUN : state;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= run ? clr_ptr : clr_ptr + 1'b1;
        end

    // Later ports overwrite earlier ones in the loop, so the highest port index wins.
    always_ff @(posedge clk)
        if (!run) regs[clr_ptr] <= '0;
        else
            for (int j = 0; j < NUM_WR; j++)
                if (wr_act[j] && |wn[j]) regs[wn[j]] <= wd[j];

    regfile_scoreboard #(
        .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_W(ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_act),
        .wr_num    (bus.wr_num),
        .sb_set_en (bus.sb_set_en & run),
        .sb_set_num(bus.sb_set_num),
        .rd_num    (bus.rd_num),
        .rd_busy   (sb_busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rn;
        logic [DATA_W-1:0] d;
        logic              b;
        assign rn = bus.rd_num[slice_lo(i, ADDR_W) +: ADDR_W];
        always_comb begin
            d = (run && |rn) ? regs[rn] : '0;
            b = run && sb_busy[i];
`ifdef REGFILE_BYPASS_EN
            // A matching writeback resolves the hazard unless the same index is re-issued this cycle.
            for (int j = 0; j < NUM_WR; j++)
                if (wr_act[j] && |rn && wn[j] == rn) begin
                    d = wd[j];
                    b = bus.sb_set_en && bus.sb_set_num == rn;
                end
`endif
        end
        assign bus.rd_data[slice_lo(i, DATA_W) +: DATA_W] = d;
        assign bus.rd_busy[i] = b;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with two read and two write ports
module tb_regfile_mp;
    localparam int DW = 32, NR = 32, NRD = 2, NWR = 2, AW = 5;
    localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        logic [8*12-1:0] name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();
    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Monitor: kind 0 = ready, 1 = rd_data[port], 2 = rd_busy[port]
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = e.kind == 0 ? 32'(bus.ready) :
                  e.kind == 1 ? bus.rd_data[e.port*DW +: DW] : 32'(bus.rd_busy[e.port]);
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %0s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = '0;
        bus.sb_set_en = 1'b0;
    endtask

    task automatic rd(input int p, input int n);
        bus.rd_num[p*AW +: AW] = AW'(n);
    endtask

    task automatic wr(input int p, input int n, input logic [31:0] d);
        bus.wr_en[p] = 1'b1;
        bus.wr_num[p*AW +: AW] = AW'(n);
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic sbset(input int n);
        bus.sb_set_en = 1'b1;
        bus.sb_set_num = AW'(n);
    endtask

    task automatic chk(input int kind, input int port, input logic [31:0] v, input logic [8*12-1:0] nm);
        q.push_back('{cyc, kind, port, v, nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.rd_num = '0;
        bus.wr_num = '0;
        bus.wr_data = '0;
        bus.sb_set_num = '0;
        idle();
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin
            step();
            n++;
        end
        compared++;
        if (!bus.ready) begin
            mismatched++;
            $display("FAIL init_ready: got 0 expected 1");
        end
        for (int i = 1; i < NR; i++) begin
            wr(0, i, 32'hDEADBEEF);
            step();
        end
        idle();
        rd(0, 7);
        rd(1, 31);
        chk(1, 0, 32'hDEADBEEF, "fill");
        chk(1, 1, 32'hDEADBEEF, "fill");
        step();

        rst_n = 1'b0;
        chk(0, 0, 0, "rst_ready");
        repeat (3) step();
        rst_n = 1'b1;
        rd(0, 7);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 9) begin
                wr(0, 5, 32'h1234);
                sbset(5);
            end
            if (k == 10) idle();
            chk(0, 0, (k == 32) ? 32'd1 : 32'd0, "clr_ready");
            if (k < 32) chk(1, 0, 0, "clr_rdata");
            if (k < 32) chk(2, 0, 0, "clr_rbusy");
        end
        for (int i = 0; i < NR; i++) begin
            rd(0, i);
            rd(1, 31 - i);
            chk(1, 0, 0, "clr_zero");
            chk(1, 1, 0, "clr_zero");
            if (i == 5) chk(2, 0, 0, "clr_sbset");
            step();
        end

        wr(0, 7, 32'hA5A5A5A5);
        step();
        idle();
        rd(0, 7);
        rd(1, 7);
        chk(1, 0, 32'hA5A5A5A5, "wr_rd");
        chk(1, 1, 32'hA5A5A5A5, "wr_rd");
        step();
        wr(0, 0, 32'hFFFFFFFF);
        step();
        idle();
        rd(0, 0);
        rd(1, 0);
        chk(1, 0, 0, "r0_zero");
        chk(1, 1, 0, "r0_zero");
        step();
        wr(0, 3, 32'h11);
        wr(1, 3, 32'h22);
        step();
        idle();
        rd(0, 3);
        rd(1, 7);
        chk(1, 0, 32'h22, "wr_conflict");
        chk(1, 1, 32'hA5A5A5A5, "wr_other");
        step();

        rd(0, 9);
        sbset(9);
        chk(2, 0, 0, "sb_pre");
        step();
        idle();
        chk(2, 0, 1, "sb_set");
        wr(0, 9, 32'h99);
        chk(2, 0, BYP ? 32'd0 : 32'd1, "sb_wrcyc");
        step();
        idle();
        chk(2, 0, 0, "sb_clr");
        wr(0, 9, 32'h77);
        sbset(9);
        step();
        idle();
        chk(2, 0, 1, "sb_both");
        chk(1, 0, 32'h77, "sb_data");
        sbset(0);
        rd(1, 0);
        step();
        idle();
        chk(2, 1, 0, "sb_r0");
        step();

        wr(0, 4, 32'h1111);
        step();
        idle();
        wr(0, 4, 32'hCAFE);
        rd(0, 4);
        chk(1, 0, BYP ? 32'hCAFE : 32'h1111, "bypass_cyc");
        step();
        idle();
        chk(1, 0, 32'hCAFE, "bypass_next");
        step();

        rst_n = 1'b0;
        chk(0, 0, 0, "mid_ready");
        chk(1, 0, 0, "mid_rdata");
        step();
        step();
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
